tx_frame_arb: RTL and testbench

TX_FRAME_ARB -- requirements
Module: tx_frame_arb

---
 rtl/tx_frame_arb.sv | 164 ++++++++++++++++
 tb/tb_tx_frame_arb.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arb.sv
// Two-client frame arbiter for a byte-wide UART transmitter. Each granted
// request becomes a 4-byte frame: header, data high, data low, checksum.
module tx_frame_arb #(
    parameter logic [7:0] HDR0   = 8'hA5,
    parameter logic [7:0] HDR1   = 8'h5A,
    parameter int         TO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        gnt_id,
    output logic        err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    localparam int TW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    state_t        r_state;
    logic          r_trmt;
    logic [7:0]    r_tx_data;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_gnt;
    logic          r_err;
    logic          r_rr_last;
    logic [7:0]    r_hdr;
    logic [15:0]   r_pay;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_to_cnt;

    logic          w_any_req;
    logic          w_pick1;
    logic [7:0]    w_hdr_new;
    logic [15:0]   w_pay_new;
    logic [7:0]    w_sum;
    logic [7:0]    w_csum;
    logic [1:0]    w_next_idx;
    logic [7:0]    w_next_byte;

    // Round robin: on a tie, the client not granted last wins. r_rr_last
    // resets to 1 so client 0 takes the first tie after reset.
    assign w_any_req = req0 | req1;
    assign w_pick1   = req1 & (~req0 | ~r_rr_last);
    assign w_hdr_new = w_pick1 ? HDR1 : HDR0;
    assign w_pay_new = w_pick1 ? data1 : data0;

    // Checksum is built only from the latched frame, never from live inputs.
    assign w_sum      = r_hdr + r_pay[15:8] + r_pay[7:0];
    assign w_csum     = ~w_sum;
    assign w_next_idx = r_idx + 2'd1;

    always_comb begin
        w_next_byte = r_hdr;
        case (w_next_idx)
            2'd1:    w_next_byte = r_pay[15:8];
            2'd2:    w_next_byte = r_pay[7:0];
            2'd3:    w_next_byte = w_csum;
            default: w_next_byte = r_hdr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_busy    <= 1'b0;
            r_gnt     <= 1'b0;
            r_err     <= 1'b0;
            r_rr_last <= 1'b1;
            r_hdr     <= 8'h00;
            r_pay     <= 16'h0000;
            r_idx     <= 2'd0;
            r_to_cnt  <= '0;
        end else begin
            r_trmt <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_done && w_any_req) begin
                        r_state   <= SEND;
                        r_busy    <= 1'b1;
                        r_gnt     <= w_pick1;
                        r_rr_last <= w_pick1;
                        r_hdr     <= w_hdr_new;
                        r_pay     <= w_pay_new;
                        r_idx     <= 2'd0;
                        r_trmt    <= 1'b1;
                        r_tx_data <= w_hdr_new;
                        r_ack0    <= ~w_pick1;
                        r_ack1    <= w_pick1;
                    end
                end
                SEND: begin
                    r_state  <= WAIT_LO;
                    r_to_cnt <= '0;
                end
                WAIT_LO: begin
                    // A transmitter that never drops tx_done means the byte
                    // was not accepted; abandon the whole frame.
                    if (!tx_done) begin
                        r_state <= WAIT_HI;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_err    <= 1'b1;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (tx_done) begin
                        if (r_idx != 2'd3) begin
                            r_idx     <= w_next_idx;
                            r_state   <= SEND;
                            r_trmt    <= 1'b1;
                            r_tx_data <= w_next_byte;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trmt        = r_trmt;
    assign tx_data     = r_tx_data;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign busy        = r_busy;
    assign gnt_id      = r_gnt;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_frame_arb.sv
// Directed bench for tx_frame_arb with a simple UART transmitter model
// that holds tx_done low for a fixed number of cycles after each trmt.
module tb_tx_frame_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] data0 = 16'h0000;
    logic        ack0;
    logic        req1 = 1'b0;
    logic [15:0] data1 = 16'h0000;
    logic        ack1;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        gnt_id;
    logic        err;
    logic [1:0]  dbg_state;

    logic        model_en = 1'b1;
    logic        td_forced = 1'b1;
    int          m_cnt = 0;

    int          n_vec = 0;
    int          n_miss = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic        gnt_q[$];
    int          trmt_total = 0;
    int          ack0_total = 0;
    int          ack1_total = 0;
    int          err_total = 0;
    int          both_ack = 0;
    int          bad_trmt = 0;

    tx_frame_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Transmitter model: idle high, low for 5 cycles after each trmt.
    assign tx_done = model_en ? (m_cnt == 0) : td_forced;

    always @(posedge clk) begin
        if (trmt) m_cnt <= 5;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end

    always @(negedge clk) begin
        if (trmt) begin
            got_q.push_back(tx_data);
            trmt_total <= trmt_total + 1;
        end
        if (ack0) begin
            gnt_q.push_back(1'b0);
            ack0_total <= ack0_total + 1;
        end
        if (ack1) begin
            gnt_q.push_back(1'b1);
            ack1_total <= ack1_total + 1;
        end
        if (ack0 && ack1) both_ack <= both_ack + 1;
        if (trmt && dbg_state != 2'd1) bad_trmt <= bad_trmt + 1;
        if (err) err_total <= err_total + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if ((which ? ack1 : ack0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_vec++;
        if ({trmt, ack0, ack1, busy, err, gnt_id} !== 6'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl: got %b expected 000000", {trmt, ack0, ack1, busy, err, gnt_id});
        end
        n_vec++;
        if (tx_data !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        n_vec++;
        if (dbg_state !== 2'd0) begin
            n_miss++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit ok;
        int base = got_q.size();
        int a0 = ack0_total;
        int a1 = ack1_total;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h14};
        data0 = 16'h1234;
        req0 = 1'b1;
        wait_ack(1'b0, 20, ok);
        n_vec++;
        if (!ok || trmt !== 1'b1 || tx_data !== 8'hA5) begin
            n_miss++;
            $display("FAIL single_ack: got ok=%0d trmt=%b tx_data=%h expected ok=1 trmt=1 tx_data=a5", ok, trmt, tx_data);
        end
        req0 = 1'b0;
        wait_idle(200, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL single_idle: got busy=%b expected 0 within budget", busy);
        end
        n_vec++;
        if (got_q.size() - base !== 4) begin
            n_miss++;
            $display("FAIL single_count: got %0d bytes expected 4", got_q.size() - base);
        end
        for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[base + i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL single_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
        n_vec++;
        if (ack0_total - a0 !== 1 || ack1_total - a1 !== 0) begin
            n_miss++;
            $display("FAIL single_acks: got ack0=%0d ack1=%0d expected 1 0", ack0_total - a0, ack1_total - a1);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int base;
        int gbase;
        int acks0;
        apply_reset();
        base = got_q.size();
        gbase = gnt_q.size();
        acks0 = ack0_total + ack1_total;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h14, 8'h5A, 8'h00, 8'hFF, 8'hA6,
                  8'hA5, 8'h12, 8'h34, 8'h14, 8'h5A, 8'h00, 8'hFF, 8'hA6};
        data0 = 16'h1234;
        data1 = 16'h00FF;
        req0 = 1'b1;
        req1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (ack0_total + ack1_total - acks0 == 4) begin
                ok = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL fair_acks: got %0d acks expected 4", ack0_total + ack1_total - acks0);
        end
        wait_idle(200, ok);
        for (int i = 0; i < 4 && gbase + i < gnt_q.size(); i++) begin
            n_vec++;
            if (gnt_q[gbase + i] !== 1'(i % 2)) begin
                n_miss++;
                $display("FAIL fair_order%0d: got client %0d expected %0d", i, gnt_q[gbase + i], i % 2);
            end
        end
        n_vec++;
        if (got_q.size() - base !== 16) begin
            n_miss++;
            $display("FAIL fair_count: got %0d bytes expected 16", got_q.size() - base);
        end
        for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[base + i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL fair_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_late_request();
        bit ok;
        int k;
        int base = got_q.size();
        exp_q = '{8'hA5, 8'hBE, 8'hEF, 8'hAD, 8'h5A, 8'h01, 8'h02, 8'hA2};
        data0 = 16'hBEEF;
        req0 = 1'b1;
        wait_ack(1'b0, 20, ok);
        req0 = 1'b0;
        data0 = 16'hDEAD;
        step();
        step();
        data1 = 16'h0102;
        req1 = 1'b1;
        wait_idle(200, ok);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (ack1 === 1'b1) begin
                k = i;
                break;
            end
        end
        req1 = 1'b0;
        n_vec++;
        if (k !== 1) begin
            n_miss++;
            $display("FAIL late_grant_delay: got %0d cycles expected 1", k);
        end
        wait_idle(200, ok);
        n_vec++;
        if (got_q.size() - base !== 8) begin
            n_miss++;
            $display("FAIL late_count: got %0d bytes expected 8", got_q.size() - base);
        end
        for (int i = 0; i < 8 && base + i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[base + i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL late_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        int t0 = trmt_total;
        int e0 = err_total;
        model_en = 1'b0;
        td_forced = 1'b1;
        data1 = 16'h00FF;
        req1 = 1'b1;
        wait_ack(1'b1, 20, ok);
        req1 = 1'b0;
        n_vec++;
        if (!ok || tx_data !== 8'h5A) begin
            n_miss++;
            $display("FAIL timeout_start: got ok=%0d tx_data=%h expected ok=1 tx_data=5a", ok, tx_data);
        end
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (err === 1'b1) begin
                k = i;
                break;
            end
        end
        n_vec++;
        if (k !== 17) begin
            n_miss++;
            $display("FAIL timeout_err_delay: got %0d cycles expected 17", k);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (trmt_total - t0 !== 1 || err_total - e0 !== 1) begin
            n_miss++;
            $display("FAIL timeout_pulses: got trmt=%0d err=%0d expected 1 1", trmt_total - t0, err_total - e0);
        end
        model_en = 1'b1;
        step();
    endtask

    task automatic test_mid_reset();
        bit ok;
        int t0;
        data1 = 16'h1234;
        req1 = 1'b1;
        wait_ack(1'b1, 20, ok);
        req1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (trmt === 1'b1 && tx_data === 8'h12) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL midrst_byte2: got no second byte expected 12");
        end
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({trmt, ack0, ack1, busy, err, gnt_id} !== 6'b0 || tx_data !== 8'h00) begin
            n_miss++;
            $display("FAIL midrst_async: got ctrl=%b tx_data=%h expected 000000 00", {trmt, ack0, ack1, busy, err, gnt_id}, tx_data);
        end
        step();
        rst = 1'b0;
        t0 = trmt_total;
        for (int i = 0; i < 30; i++) step();
        n_vec++;
        if (trmt_total - t0 !== 0) begin
            n_miss++;
            $display("FAIL midrst_no_trmt: got %0d trmt expected 0", trmt_total - t0);
        end
    endtask

    task automatic test_blocked_start();
        bit ok;
        int base;
        int t0;
        int a0;
        rst = 1'b1;
        model_en = 1'b0;
        td_forced = 1'b0;
        data0 = 16'h1234;
        req0 = 1'b1;
        step();
        rst = 1'b0;
        t0 = trmt_total;
        a0 = ack0_total;
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (trmt_total - t0 !== 0 || ack0_total - a0 !== 0 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL blocked_hold: got trmt=%0d ack0=%0d busy=%b expected 0 0 0", trmt_total - t0, ack0_total - a0, busy);
        end
        base = got_q.size();
        model_en = 1'b1;
        step();
        n_vec++;
        if (ack0 !== 1'b1 || trmt !== 1'b1) begin
            n_miss++;
            $display("FAIL blocked_grant: got ack0=%b trmt=%b expected 1 1", ack0, trmt);
        end
        req0 = 1'b0;
        wait_idle(200, ok);
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h14};
        n_vec++;
        if (got_q.size() - base !== 4) begin
            n_miss++;
            $display("FAIL blocked_count: got %0d bytes expected 4", got_q.size() - base);
        end
        for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[base + i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL blocked_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_invariants();
        n_vec++;
        if (both_ack !== 0) begin
            n_miss++;
            $display("FAIL ack_exclusive: got %0d overlaps expected 0", both_ack);
        end
        n_vec++;
        if (bad_trmt !== 0) begin
            n_miss++;
            $display("FAIL trmt_only_send: got %0d stray trmt expected 0", bad_trmt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_late_request();
        test_timeout();
        test_mid_reset();
        test_blocked_start();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
